// File: rtl/soc_uart_rx.sv
// -----------------------------------------------------------------------------
// soc_uart_rx
// UART receive stage with 16x oversampling. It deserializes 8N1 frames from the
// asynchronous `sin` line (8E1 when SOC_UART_RX_PARITY_EN is defined). Received
// bytes are held in a one-entry valid/ready buffer for the register block.
// Framing, overrun and (optionally) parity errors are reported as sticky flags.
//
// Configuration macro:
//   SOC_UART_RX_PARITY_EN  - adds the PARITY state (even parity, 8E1 frames).
//                            When undefined, parity_err is tied to 0.
//
// Parameters:
//   SYNC_STAGES  number of sin synchronizer flops (minimum 2)
//   DIV_WIDTH    width of clk_divider
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sin          serial receive line, idle high, asynchronous to clk
//   rx_en        receiver enable; 0 forces the FSM back to IDLE
//   clk_divider  oversample tick period minus 1, in clk cycles
//   rx_data      received byte (stable while rx_valid=1)
//   rx_valid     rx_data holds an unread byte
//   rx_ready     consumer accepts the byte when rx_valid && rx_ready
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: a byte completed while rx_valid was still set
//   parity_err   sticky: parity mismatch (0 without the parity feature)
//   err_clear    single-cycle pulse that clears all sticky flags
//   busy         FSM is not in IDLE
// -----------------------------------------------------------------------------
module soc_uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  input  logic                 rx_en,
  input  logic [DIV_WIDTH-1:0] clk_divider,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  input  logic                 err_clear,
  output logic                 busy
);

`ifdef SOC_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sin_s;
  logic                   r_sin_prev;

  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [DIV_WIDTH-1:0]   r_div_lat;
  logic [3:0]             r_tick_cnt;
  logic                   w_tick;
  logic                   w_sample;

  logic [7:0]             r_shift;
  logic [2:0]             r_bit_idx;

  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun_err;

  logic                   w_start;
  logic                   w_shift_en;
  logic                   w_deliver;
  logic                   w_frame_set;
  logic                   w_par_set;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge-detect history
  // ---------------------------------------------------------------------------
  // NOTE: the synchronizer resets to 1 so the idle line does not look like a
  // falling edge (false start bit) when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_sin_prev <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sin};
      r_sin_prev <= w_sin_s;
    end
  end

  assign w_sin_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Oversample tick generator and per-bit tick counter.
  // The divider is captured at each wrap (and at start), so a mid-frame change
  // to clk_divider only applies from the next wrap.
  // ---------------------------------------------------------------------------
  assign w_tick   = (r_div_cnt == r_div_lat);
  assign w_sample = w_tick && (r_tick_cnt == 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_div_lat  <= '0;
      r_tick_cnt <= '0;
    end else if (w_start) begin
      // Align sampling to the detected start edge.
      r_div_cnt  <= '0;
      r_div_lat  <= clk_divider;
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt  <= '0;
      r_div_lat  <= clk_divider;
      r_tick_cnt <= r_tick_cnt + 4'd1;
    end else begin
      r_div_cnt  <= r_div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    w_frame_set = 1'b0;
    w_par_set   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_en && r_sin_prev && !w_sin_s) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        // Line back high at mid start bit: treat as a glitch, no error.
        if (w_sample) w_state_nxt = w_sin_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef SOC_UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef SOC_UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          // Even parity: data bits plus parity bit must XOR to 0.
          w_par_set   = ^{r_shift, w_sin_s};
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Return to IDLE at mid stop bit so back-to-back frames are not missed.
        if (w_sample) begin
          w_deliver   = w_sin_s;
          w_frame_set = !w_sin_s;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Disable aborts any frame in progress without side effects.
    if (!rx_en) begin
      w_state_nxt = S_IDLE;
      w_start     = 1'b0;
      w_shift_en  = 1'b0;
      w_deliver   = 1'b0;
      w_frame_set = 1'b0;
      w_par_set   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserializer (LSB first: each new bit enters at the MSB and shifts down)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_shift_en) begin
      r_shift   <= {w_sin_s, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end else if (r_state == S_IDLE) begin
      r_bit_idx <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output buffer and sticky error flags (set wins over clear)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_overrun_err <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if (w_deliver && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_deliver && r_rx_valid && !rx_ready) r_overrun_err <= 1'b1;
      else if (err_clear)                       r_overrun_err <= 1'b0;

      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
    end
  end

`ifdef SOC_UART_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_parity_err <= 1'b0;
    else if (w_par_set) r_parity_err <= 1'b1;
    else if (err_clear) r_parity_err <= 1'b0;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_soc_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_soc_uart_rx
// Directed testbench for soc_uart_rx. Frames are driven bit by bit on sin; a
// negedge monitor records every rising edge of rx_valid with its data byte.
// Define SOC_UART_RX_PARITY_EN for both bench and RTL to cover the 8E1 build.
// -----------------------------------------------------------------------------
module tb_soc_uart_rx;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        rx_en;
  logic [15:0] clk_divider;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun_err;
  logic        parity_err;
  logic        err_clear;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef SOC_UART_RX_PARITY_EN
  localparam int LAT_MAX = 2 + 160 + 16;
`else
  localparam int LAT_MAX = 2 + 160;
`endif

  soc_uart_rx #(.SYNC_STAGES(2), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .rx_en       (rx_en),
    .clk_divider (clk_divider),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and rx_valid monitor.
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  int         valid_pulses = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      valid_pulses++;
      rx_q.push_back(rx_data);
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  // Drives one frame. act_kind 1 drops rx_en, 2 pulses rst_n, both at the
  // middle of frame bit act_bit (bit 0 = start bit).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bad, input int act_bit,
                            input int act_kind);
    logic [10:0] bits;
    int          nbits;
    int          bit_clks;
    bit_clks = 16 * (int'(clk_divider) + 1);
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = data;
`ifdef SOC_UART_RX_PARITY_EN
    bits[9]  = (^data) ^ par_bad;
    bits[10] = stop_bit;
    nbits    = 11;
`else
    bits[9]  = stop_bit;
    nbits    = 10;
`endif
    @(posedge clk); #1;
    for (int b = 0; b < nbits; b++) begin
      sin = bits[b];
      if (b == 0) start_cyc = cyc;
      for (int c = 0; c < bit_clks; c++) begin
        if (b == act_bit && c == bit_clks / 2) begin
          if (act_kind == 1) rx_en = 1'b0;
          if (act_kind == 2) rst_n = 1'b0;
        end
        if (b == act_bit && act_kind == 2 && c == bit_clks / 2 + 3) rst_n = 1'b1;
        @(posedge clk); #1;
      end
    end
    sin = 1'b1;
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b oe=%b pe=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun_err, parity_err, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rx_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got v=%b busy=%b, expected 0 0", rx_valid, busy);
    end
  endtask

  task automatic test_basic();
    clk_divider = 16'd0;
    rx_ready    = 1'b0;
    rise_cyc    = -1;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_rx: got v=%b data=%h, expected v=1 data=a5", rx_valid, rx_data);
    end
    tests_run++;
    if (rise_cyc < start_cyc || (rise_cyc - start_cyc) > LAT_MAX) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d clk, expected 0..%0d", rise_cyc - start_cyc, LAT_MAX);
    end
    tests_run++;
    if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL basic_errs: got fe=%b oe=%b pe=%b, expected 0 0 0",
               frame_err, overrun_err, parity_err);
    end
  endtask

  task automatic test_overrun();
    int n0;
    n0 = valid_pulses;
    send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (overrun_err !== 1'b1 || rx_data !== 8'hA5 || rx_valid !== 1'b1 || valid_pulses != n0) begin
      tests_failed++;
      $display("FAIL overrun: got oe=%b data=%h v=%b pulses=%0d, expected oe=1 data=a5 v=1 pulses=%0d",
               overrun_err, rx_data, rx_valid, valid_pulses, n0);
    end
    pulse_ready();
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_consume: got v=%b, expected 0", rx_valid);
    end
    pulse_clear();
    @(negedge clk);
    tests_run++;
    if (overrun_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got oe=%b, expected 0", overrun_err);
    end
  endtask

  task automatic test_glitch();
    int   n0;
    logic seen_busy;
    n0        = valid_pulses;
    seen_busy = 1'b0;
    @(posedge clk); #1 sin = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    sin = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    tests_run++;
    if (seen_busy !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_busy: got seen=%b busy=%b, expected seen=1 busy=0", seen_busy, busy);
    end
    tests_run++;
    if (rx_valid !== 1'b0 || valid_pulses != n0 || {frame_err, overrun_err, parity_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got v=%b pulses=%0d fe=%b oe=%b pe=%b, expected v=0 pulses=%0d no errors",
               rx_valid, valid_pulses, frame_err, overrun_err, parity_err, n0);
    end
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = valid_pulses;
    send_frame(8'hFF, 1'b0, 1'b0, -1, 0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b1 || rx_valid !== 1'b0 || valid_pulses != n0) begin
      tests_failed++;
      $display("FAIL frame_err: got fe=%b v=%b pulses=%0d, expected fe=1 v=0 pulses=%0d",
               frame_err, rx_valid, valid_pulses, n0);
    end
    pulse_clear();
    @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_clear: got fe=%b, expected 0", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int         n0;
    logic [7:0] exp_b [3];
    logic [7:0] got;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'h55;
    exp_b[2] = 8'hFF;
    clk_divider = 16'd3;
    rx_ready    = 1'b1;
    rx_q.delete();
    n0 = valid_pulses;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0, -1, 0);
    repeat (8) @(negedge clk);
    tests_run++;
    if (valid_pulses - n0 != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d pulses, expected 3", valid_pulses - n0);
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL b2b_data%0d: got %h, expected %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (overrun_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overrun: got oe=%b, expected 0", overrun_err);
    end
  endtask

  task automatic test_abort();
    int n0;
    clk_divider = 16'd0;
    n0 = valid_pulses;
    // rx_en dropped during data bit 3 (frame bit 4).
    send_frame(8'h5A, 1'b1, 1'b0, 4, 1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || valid_pulses != n0 || rx_data !== 8'hFF) begin
      tests_failed++;
      $display("FAIL disable_abort: got busy=%b pulses=%0d data=%h, expected busy=0 pulses=%0d data=ff",
               busy, valid_pulses, rx_data, n0);
    end
    rx_en = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0, 4, 2);
    repeat (4) @(negedge clk);
    tests_run++;
    if ({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy} !== 13'h0 || valid_pulses != n0) begin
      tests_failed++;
      $display("FAIL reset_abort: got data=%h v=%b fe=%b oe=%b pe=%b busy=%b pulses=%0d, expected zeros pulses=%0d",
               rx_data, rx_valid, frame_err, overrun_err, parity_err, busy, valid_pulses, n0);
    end
    rx_q.delete();
    send_frame(8'h12, 1'b1, 1'b0, -1, 0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (valid_pulses != n0 + 1 || rx_q.size() != 1 || rx_data !== 8'h12) begin
      tests_failed++;
      $display("FAIL after_reset_rx: got pulses=%0d data=%h, expected pulses=%0d data=12",
               valid_pulses, rx_data, n0 + 1);
    end
  endtask

`ifdef SOC_UART_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b0;
    // 8'h07 has three ones: even parity bit would be 1, so send 0.
    send_frame(8'h07, 1'b1, 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h07 || rx_valid !== 1'b1 || parity_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_err: got data=%h v=%b pe=%b, expected data=07 v=1 pe=1",
               rx_data, rx_valid, parity_err);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    sin         = 1'b1;
    rx_en       = 1'b1;
    clk_divider = 16'd0;
    rx_ready    = 1'b0;
    err_clear   = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_abort();
`ifdef SOC_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/soc_uart_rx.md
Name: soc_uart_rx

Overview:
- UART receive stage. Consumes the serial line driven into the SoC UART bus (the `sin` signal as seen by the master side).
- Deserializes 8N1 frames (optionally 8E1) using 16x oversampling.
- Presents received bytes to the UART peripheral register block through a one-entry valid/ready buffer.
- Flags framing and overrun errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `sin` synchronizer (minimum 2).
- DIV_WIDTH, 16, width of the `clk_divider` input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial receive line, idle high, asynchronous to clk
- rx_en  input  1  receiver enable; 0 holds the FSM in IDLE
- clk_divider  input  DIV_WIDTH  oversample tick period minus 1, in clk cycles
- rx_data  output  8  received byte
- rx_valid  output  1  rx_data holds an unread byte
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready
- frame_err  output  1  sticky: stop bit sampled low
- overrun_err  output  1  sticky: a new byte completed while rx_valid was still 1
- parity_err  output  1  sticky parity error (tied 0 when the feature is disabled)
- err_clear  input  1  single-cycle pulse; clears all sticky errors
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; all counters reset to 0.
  - Outputs: rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0, parity_err=0, busy=0.
  - Synchronizer flops reset to 1 (idle line).
- Synchronizer: `sin` passes through SYNC_STAGES flops; all logic uses the synchronized `sin_s`.
- Tick generator:
  - Counter runs 0..clk_divider and emits a one-cycle tick at terminal count, then wraps to 0.
  - clk_divider=0 gives a tick every cycle.
  - The counter is cleared on entry to START, so sampling is aligned to the start edge.
- Bit timing: 16 ticks per bit. The sample point is tick index 7 of each bit (0-based), counted with a 4-bit tick counter.
- FSM states:
  - IDLE → START when rx_en=1 and sin_s falls (1 in the previous cycle, 0 now).
  - START: on tick 7, if sin_s=0 go to DATA with bit index 0; otherwise go back to IDLE (glitch reject, no error).
  - DATA: at each mid-bit sample, shift sin_s in LSB-first. After bit index 7 go to PARITY if the feature is enabled, else to STOP.
  - PARITY (feature only): sample the parity bit, then go to STOP.
  - STOP: at the mid-bit sample:
    - sin_s=0 → set frame_err and discard the byte.
    - sin_s=1 → deliver the byte.
    - In both cases return to IDLE immediately, without waiting for the full stop bit, so back-to-back frames are accepted.
- Delivery (on the clock edge after the stop sample):
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle → load rx_data and assert rx_valid.
  - rx_valid=1 and rx_ready=0 → keep the old rx_data, set overrun_err, drop the new byte.
- Handshake:
  - rx_valid stays high until the cycle where rx_valid && rx_ready; it clears on the following edge.
  - rx_data is stable while rx_valid=1.
- Disable: rx_en=0 mid-frame aborts to IDLE on the next edge and delivers no byte. rx_valid and the error flags are unaffected.
- Divider changes: a change to clk_divider mid-frame takes effect at the next tick-counter wrap. No protection is provided; software changes it only while busy=0.
- err_clear:
  - Clears all sticky flags on the next edge.
  - If err_clear coincides with a new error event, the set wins.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: SOC_UART_RX_PARITY_EN.
- Defined:
  - The PARITY state exists and frames are 8E1.
  - parity_err is set when XOR(data[7:0], parity_bit) != 0.
  - A byte with a parity error is still delivered, provided the stop bit is good.
- Undefined:
  - No PARITY state; frames are 8N1.
  - parity_err is tied to 0.

Test Plan:
- clk_divider=0, rx_en=1, rx_ready=0, send 8'hA5 (bit = 16 clk) → rx_valid=1 with rx_data=8'hA5 within 2+160 clk of the start edge (plus 16 clk with parity enabled); no error flags set.
- With 8'hA5 still unread, send 8'h3C → overrun_err=1, rx_data stays 8'hA5. Then pulse rx_ready → rx_valid=0 the next cycle. Pulse err_clear → overrun_err=0.
- 4-clk low glitch on sin in IDLE with clk_divider=0 → FSM returns to IDLE after the START sample; busy drops; no rx_valid and no errors.
- Send 8'hFF with the stop bit forced to 0 → frame_err=1, rx_valid stays 0.
- clk_divider=3, rx_ready tied to 1, three back-to-back frames 8'h00, 8'h55, 8'hFF → three rx_valid pulses with matching data; no overrun.
- Assert rx_en=0 during data bit 3, then rst_n=0 mid-frame on a second frame → no delivery in either case. After reset, all outputs are at their reset values and the next frame 8'h12 is received correctly.
- Parity build only: send 8'h07 with parity bit 0 → rx_data=8'h07, rx_valid=1, parity_err=1.
